// File: rtl/shift_register_piso_stream.sv
// Parallel-in serial-out shifter with valid/ready load, one-word holding buffer,
// selectable bit order, per-word length and a fixed idle line level.
module shift_register_piso_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          IDLE_BIT  = 1'b0,
  parameter bit          COVER     = 1'b0,
  localparam int unsigned LW       = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             abort_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] value_i,
  input  logic [LW-1:0]    len_i,
  input  logic             advance_i,
  output logic             bit_o,
  output logic             busy_o,
  output logic             last_o,
  output logic             done_o
);

  localparam logic [LW-1:0] WL = LW'(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold_data;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    hold_len;
  logic             busy;
  logic             hold_valid;
  logic             done_q;

  logic [LW-1:0]    len_c;
  logic [WIDTH-1:0] aligned;
  logic             accept;
  logic             last;
  logic             finishing;

  // Words are stored pre-aligned so the shifter always emits from a fixed end.
  always_comb begin
    len_c = len_i;
    if (len_i == '0 || len_i > WL) begin
      len_c = WL;
    end
    aligned = value_i;
    if (MSB_FIRST) begin
      aligned = value_i << (WIDTH - 32'(len_c));
    end
  end

  assign ready_o   = !hold_valid && !abort_i && !rst_i;
  assign accept    = valid_i && ready_o;
  assign last      = busy && (cnt == LW'(1));
  assign finishing = advance_i && last;

  assign busy_o = busy;
  assign last_o = last;
  assign done_o = done_q;
  assign bit_o  = busy ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_BIT;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr         <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_len   <= '0;
      done_q     <= 1'b0;
    end else if (abort_i) begin
      busy       <= 1'b0;
      hold_valid <= 1'b0;
      cnt        <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= finishing;
      if (!busy || finishing) begin
        if (hold_valid) begin
          sr         <= hold_data;
          cnt        <= hold_len;
          busy       <= 1'b1;
          hold_valid <= 1'b0;
        end else if (accept) begin
          sr   <= aligned;
          cnt  <= len_c;
          busy <= 1'b1;
        end else begin
          busy <= 1'b0;
        end
      end else begin
        if (advance_i) begin
          if (MSB_FIRST) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
          end else begin
            sr <= {1'b0, sr[WIDTH-1:1]};
          end
          cnt <= cnt - LW'(1);
        end
        if (accept) begin
          hold_data  <= aligned;
          hold_len   <= len_c;
          hold_valid <= 1'b1;
        end
      end
    end
  end

  if (COVER) begin : g_cover
    cover property (@(posedge clk_i) disable iff (rst_i) done_q && busy);
    cover property (@(posedge clk_i) disable iff (rst_i) hold_valid && finishing);
  end

endmodule

// File: tb/tb_shift_register_piso_stream.sv
// Directed and random stimulus for LSB-first and MSB-first instances, checked
// every cycle against a word-queue reference model.
module tb_shift_register_piso_stream;

  logic       clk = 1'b0;
  logic       rst, abort, valid, adv;
  logic [7:0] value;
  logic [3:0] len;

  logic l_ready, l_bit, l_busy, l_last, l_done;
  logic m_ready, m_bit, m_busy, m_last, m_done;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of accepted words (front = shifting, second = held)
  logic [7:0] qv[$];
  int         ql[$];
  int         pos = 0;
  logic       done_m = 1'b0;

  always #5 clk = ~clk;

  shift_register_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .abort_i(abort), .valid_i(valid), .ready_o(l_ready),
    .value_i(value), .len_i(len), .advance_i(adv), .bit_o(l_bit), .busy_o(l_busy),
    .last_o(l_last), .done_o(l_done)
  );

  shift_register_piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .abort_i(abort), .valid_i(valid), .ready_o(m_ready),
    .value_i(value), .len_i(len), .advance_i(adv), .bit_o(m_bit), .busy_o(m_busy),
    .last_o(m_last), .done_o(m_done)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0t got=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_ready();
    return (qv.size() < 2) && !abort && !rst;
  endfunction

  task automatic check_outputs();
    logic       e_busy, e_last, e_lbit, e_mbit;
    logic [7:0] v;
    int         L;
    e_busy = qv.size() > 0;
    e_last = 1'b0;
    e_lbit = 1'b0;
    e_mbit = 1'b1;
    if (e_busy) begin
      v = qv[0];
      L = ql[0];
      e_lbit = v[pos];
      e_mbit = v[L-1-pos];
      e_last = (pos == L - 1);
    end
    chk("lsb.ready", l_ready, exp_ready());
    chk("lsb.busy",  l_busy,  e_busy);
    chk("lsb.last",  l_last,  e_last);
    chk("lsb.done",  l_done,  done_m);
    chk("lsb.bit",   l_bit,   e_lbit);
    chk("msb.ready", m_ready, exp_ready());
    chk("msb.busy",  m_busy,  e_busy);
    chk("msb.last",  m_last,  e_last);
    chk("msb.done",  m_done,  done_m);
    chk("msb.bit",   m_bit,   e_mbit);
  endtask

  // Advance the model by one clock edge using the pre-edge state.
  task automatic model_edge();
    logic busy_m, fin, acc;
    int   L;
    busy_m = qv.size() > 0;
    fin    = busy_m && adv && (pos == ql[0] - 1);
    acc    = valid && exp_ready();
    if (rst || abort) begin
      qv.delete();
      ql.delete();
      pos    = 0;
      done_m = 1'b0;
    end else begin
      done_m = fin;
      if (busy_m && adv) pos++;
      if (fin) begin
        void'(qv.pop_front());
        void'(ql.pop_front());
        pos = 0;
      end
      if (acc) begin
        L = (len == 0 || len > 8) ? 8 : int'(len);
        qv.push_back(value);
        ql.push_back(L);
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] l,
                      input logic a, input logic ab);
    valid = v; value = d; len = l; adv = a; abort = ab;
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_adv(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; valid = 1'b0; adv = 1'b0; value = '0; len = '0;
    step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    run_idle(1);

    // Full-width word, continuous advance
    step(1'b1, 8'hC1, 4'd8, 1'b0, 1'b0);
    run_adv(10);

    // Short word, then zero and over-range lengths
    step(1'b1, 8'h06, 4'd3, 1'b0, 1'b0);
    run_adv(5);
    step(1'b1, 8'h9B, 4'd0, 1'b0, 1'b0);
    run_adv(10);
    step(1'b1, 8'h64, 4'd9, 1'b0, 1'b0);
    run_adv(10);

    // Back-to-back via hold buffer, third valid stalls until space frees
    step(1'b1, 8'hA5, 4'd8, 1'b1, 1'b0);
    step(1'b1, 8'h3C, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'hF0, 4'd5, 1'b1, 1'b0);
    run_adv(16);

    // Direct chaining: accept on the last-bit advance with hold empty
    step(1'b1, 8'h5A, 4'd2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    step(1'b1, 8'h81, 4'd2, 1'b1, 1'b0);
    run_adv(4);

    // Stall mid-word then resume
    step(1'b1, 8'hC1, 4'd8, 1'b0, 1'b0);
    run_adv(3);
    run_idle(5);
    run_adv(7);

    // Abort with a word held
    step(1'b1, 8'h11, 4'd8, 1'b0, 1'b0);
    step(1'b1, 8'h22, 4'd8, 1'b1, 1'b0);
    step(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 4'd8, 1'b1, 1'b1);
    run_idle(3);

    // Asynchronous reset mid-word
    step(1'b1, 8'hE7, 4'd8, 1'b0, 1'b0);
    run_adv(3);
    valid = 1'b0; adv = 1'b0;
    #2 rst = 1'b1;
    qv.delete(); ql.delete(); pos = 0; done_m = 1'b0;
    #1 check_outputs();
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 8'h77, 4'd8, 1'b1, 1'b0);
    rst = 1'b0;
    run_idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'b1 & ($urandom_range(0, 2) != 0), 8'($urandom), 4'($urandom),
           1'b1 & ($urandom_range(0, 3) != 0), 1'b1 & ($urandom_range(0, 40) == 0));
    end
    run_adv(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_register_piso_stream.md
# shift_register_piso_stream

Parametrised parallel-in serial-out shifter with a valid/ready load interface, a one-word holding buffer for back-to-back frames, selectable bit order, per-word length and a defined idle line level. It sits between a word-oriented producer (register file, FIFO) and a bit-serial transmitter that paces the output with `advance_i`, for example an SPI/UART-style bit engine.

## Interface
- `WIDTH`, 8: maximum word width in bits, ≥ 2.
- `MSB_FIRST`, 0: 0 shifts LSB first; 1 shifts MSB first.
- `IDLE_BIT`, 0: level driven on `bit_o` while no word is being shifted.
- `COVER`, 0: formal-only; 1 enables cover properties.
- `LW` (localparam): `$clog2(WIDTH+1)`.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `abort_i`  in  1  synchronous flush of the shifter and holding buffer.
- `valid_i`  in  1  producer offers `value_i`/`len_i`.
- `ready_o`  out  1  block can accept a word this cycle.
- `value_i`  in  WIDTH  parallel word.
- `len_i`  in  LW  number of bits to send. 0 or greater than WIDTH means WIDTH.
- `advance_i`  in  1  consumer has taken the current `bit_o`.
- `bit_o`  out  1  current serial bit.
- `busy_o`  out  1  a word is being shifted.
- `last_o`  out  1  `bit_o` is the final bit of the current word.
- `done_o`  out  1  one-cycle pulse after the final bit of a word is advanced.

## Operation
**State**
- Shift register `sr[WIDTH-1:0]`, remaining-bit counter `cnt[LW-1:0]`, busy flag.
- Holding buffer `hold_data`, `hold_len`, `hold_valid`.

**Acceptance**
- A word is accepted when `valid_i && ready_o` at a clock edge.
- `ready_o = !hold_valid && !abort_i && !rst_i`.

**Load rules**, evaluated at each edge with `abort_i` = 0:
- Shifter idle, or finishing (`advance_i && last_o`):
  - If `hold_valid`, the hold word loads into `sr`/`cnt` and `hold_valid` clears.
  - Otherwise, an accepted word loads directly into `sr`/`cnt`.
  - Otherwise, busy clears.
- Shifter busy and not finishing: an accepted word goes to the hold buffer.
- The hold buffer can never be written and loaded in the same cycle, because `ready_o` = 0 whenever it is full.

**Shifting**
- `advance_i` while busy and not last:
  - LSB first: `sr` shifts right with 0 fill.
  - MSB first: `sr` shifts left with 0 fill.
  - `cnt` decrements.
- `advance_i` while idle is ignored.

**Outputs**
- `bit_o`: `sr[0]` (LSB first) or `sr[WIDTH-1]` (MSB first) when busy; `IDLE_BIT` otherwise.
- `busy_o`: the busy flag.
- `last_o = busy && cnt == 1`.

**Length rules**
- Clamp `len_i` (0 or greater than WIDTH → WIDTH) at acceptance; the stored length is the clamped value.
- MSB-first with `len` < WIDTH sends bits `[len-1:0]` from bit `len-1` down. At load, left-align by `sr = value << (WIDTH-len)`.

**Abort**
- `abort_i` at an edge clears busy, `hold_valid` and `cnt`.
- `done_o` does not pulse.
- An accepted word is impossible because `ready_o` = 0.

**Reset**
- Asynchronous. Clears busy, `hold_valid`, `cnt`, `sr` and `done_o`.
- While reset is held: `bit_o` = `IDLE_BIT`, `ready_o` = 0, `busy_o` = `last_o` = `done_o` = 0.

## Timing
- Load latency: a word accepted into an idle block at edge N drives its first bit on `bit_o` with `busy_o` = 1 in the cycle after N.
- Back-to-back: with the hold buffer full, the last-bit advance at edge N presents bit 0 of the next word in the cycle after N, with no idle cycle.
- Direct chaining: with the hold buffer empty, `valid_i` present at the last-bit advance is accepted and loaded in the same edge, also with no gap.
- `done_o` is registered: high for exactly the cycle after the edge that consumed the final bit, including when the next word loads on that edge.
- `ready_o` is combinational from `hold_valid`, `abort_i` and `rst_i` only. It has no dependence on `valid_i`.
- Throughput: one bit per `advance_i`. A word of length L needs exactly L advances.

## Test plan
- Reset, LSB first: accept 0xC1, `len` 8, `advance_i` held high → `bit_o` 1,0,0,0,0,0,1,1; `last_o` on the 8th bit; `done_o` one cycle later; then `bit_o` = `IDLE_BIT`, `busy_o` = 0.
- `MSB_FIRST` = 1: accept 0xC1, `len` 8 → 1,1,0,0,0,0,0,1. Accept 0x06, `len` 3 → 1,1,0.
- LSB first: accept 0x06, `len` 3 → 0,1,1 then idle. `len` 0 and `len` 9 each send 8 bits.
- Back-to-back: accept 0xA5, then 0x3C while busy (`ready_o` drops to 0). A third `valid_i` stalls. The 16 bits are contiguous, `done_o` pulses after bits 8 and 16, and `ready_o` returns to 1 when 0x3C leaves the hold buffer.
- Stall: advance 3 bits of 0xC1, hold `advance_i` low for 5 cycles → `bit_o` steady at 0 with `busy_o` = 1. Resuming completes the word correctly.
- Abort and reset mid-word:
  - `abort_i` after 2 bits with a word in the hold buffer → idle next cycle, `ready_o` = 1, no `done_o`.
  - `rst_i` asserted mid-word (asynchronously) → outputs go to reset values immediately, without waiting for an edge.
